// File: rtl/sa_result_writer_pkg.sv
// Shared definitions for the systolic result writer: frame defaults and TX FSM state encoding.
package sa_result_writer_pkg;

  localparam int IMG_W_DEF      = 50;
  localparam int IMG_H_DEF      = 50;
  localparam int RES_W_DEF      = 12;
  localparam int FIFO_DEPTH_DEF = 16;

  // Output column/row counters are 6 bits wide at the port.
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } tx_state_e;

endpackage

// File: rtl/sa_wr_fifo.sv
// Synchronous FIFO for converted result bytes; pointers carry an extra wrap bit for full/empty.
module sa_wr_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);

  // Full is judged before any same-cycle pop, so a full FIFO never takes a push.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/sa_result_writer.sv
// Result return path: converts window results to bytes, queues them, and feeds the UART.
// Define SA_WR_SATURATE_EN to clamp results to 0..255; otherwise the low byte is kept as is.
module sa_result_writer
  import sa_result_writer_pkg::*;
#(
  parameter int IMG_W      = IMG_W_DEF,
  parameter int IMG_H      = IMG_H_DEF,
  parameter int RES_W      = RES_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RES_W-1:0] res_data,
  input  logic             res_valid,
  output logic             res_ready,
  output logic [7:0]       tx_data,
  output logic             tx_start,
  input  logic             tx_busy,
  output logic [CNT_W-1:0] out_col,
  output logic [CNT_W-1:0] out_row,
  output logic             frame_done
);

  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(IMG_W - 3);
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(IMG_H - 3);

  tx_state_e        state_q, state_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_start_q, tx_start_d;
  logic [CNT_W-1:0] col_q, col_d;
  logic [CNT_W-1:0] row_q, row_d;
  logic             frame_done_q, frame_done_d;
  logic             ready_q;

  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_rd;
  logic       push;
  logic       pop;
  logic [7:0] res_byte;

  // Holds ready low through reset and lets it rise the cycle after release.
  always_ff @(posedge clk) begin
    if (rst) ready_q <= 1'b0;
    else     ready_q <= 1'b1;
  end

  assign res_ready = ready_q && !fifo_full;
  assign push      = res_valid && res_ready;

`ifdef SA_WR_SATURATE_EN
  always_comb begin
    res_byte = res_data[7:0];
    if (res_data[RES_W-1])         res_byte = 8'h00;
    else if (|res_data[RES_W-2:8]) res_byte = 8'hFF;
  end
`else
  logic unused_res_hi;
  assign res_byte      = res_data[7:0];
  assign unused_res_hi = ^res_data[RES_W-1:8];
`endif

  sa_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (push),
    .wr_data_i (res_byte),
    .pop_i     (pop),
    .rd_data_o (fifo_rd),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    tx_data_d    = tx_data_q;
    tx_start_d   = 1'b0;
    col_d        = col_q;
    row_d        = row_q;
    frame_done_d = 1'b0;
    pop          = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty && !tx_busy) begin
          pop        = 1'b1;
          tx_data_d  = fifo_rd;
          tx_start_d = 1'b1;
          state_d    = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (tx_busy) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = IDLE;
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              row_d        = '0;
              frame_done_d = 1'b1;
            end else begin
              row_d = row_q + CNT_W'(1);
            end
          end else begin
            col_d = col_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      tx_data_q    <= 8'h00;
      tx_start_q   <= 1'b0;
      col_q        <= '0;
      row_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tx_data_q    <= tx_data_d;
      tx_start_q   <= tx_start_d;
      col_q        <= col_d;
      row_q        <= row_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_start   = tx_start_q;
  assign out_col    = col_q;
  assign out_row    = row_q;
  assign frame_done = frame_done_q;

endmodule
